// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared scheduler state encoding and anchor width for the edge-detect chain
package edge_pkg;

    localparam int ANCHOR_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE,
        S_SETTLE,
        S_WAIT,
        S_DRAIN_MOVE,
        S_DRAIN_SETTLE,
        S_DRAIN_WAIT,
        S_DONE
    } sched_state_t;

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - clearable up-counter with enable
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;

    // clear dominates so a fresh frame always starts the count from zero
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/anchor_scheduler.sv
// rtl/anchor_scheduler.sv - raster anchor sequencer with end-of-frame pipeline drain
module anchor_scheduler
    import edge_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int WIN_STEP   = 10,
    parameter int NUM_STAGES = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic [NUM_STAGES-1:0] stage_final,
    output logic                  anchor_moving,
    output logic [ANCHOR_W-1:0]   anchor_x,
    output logic [ANCHOR_W-1:0]   anchor_y,
    output logic                  flush,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(NUM_STAGES) + 1;
    localparam logic [ANCHOR_W-1:0] X_LAST = ANCHOR_W'(IMG_WIDTH - WIN_STEP);
    localparam logic [ANCHOR_W-1:0] Y_LAST = ANCHOR_W'(IMG_HEIGHT - 1);
    localparam logic [ANCHOR_W-1:0] X_STEP = ANCHOR_W'(WIN_STEP);
    localparam logic [ANCHOR_W-1:0] X_LIM  = ANCHOR_W'(IMG_WIDTH);
    // the count is sampled before its increment, so the last drain wait sees NUM_STAGES-2
    localparam logic [CNT_W-1:0]    DRAIN_LAST = CNT_W'(NUM_STAGES - 2);

    sched_state_t          state_q, state_d;
    logic [ANCHOR_W-1:0]   anchor_x_q, anchor_x_d;
    logic [ANCHOR_W-1:0]   anchor_y_q, anchor_y_d;
    logic                  frame_done_q, frame_done_d;
    logic [CNT_W-1:0]      drain_cnt;
    logic                  all_final;
    logic                  last_anchor;
    logic                  drain_last;
    logic [ANCHOR_W-1:0]   x_plus;

    assign all_final   = &stage_final;
    assign last_anchor = (anchor_x_q == X_LAST) && (anchor_y_q == Y_LAST);
    assign drain_last  = (drain_cnt == DRAIN_LAST);
    assign x_plus      = anchor_x_q + X_STEP;

    flex_counter #(
        .NUM_CNT_BITS (CNT_W)
    ) u_drain_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (state_q == S_IDLE),
        .count_enable ((state_q == S_DRAIN_WAIT) && all_final),
        .count_out    (drain_cnt)
    );

    // next state and anchor; the anchor changes only on entry to MOVE so it is stable for the whole window
    always_comb begin
        state_d    = state_q;
        anchor_x_d = anchor_x_q;
        anchor_y_d = anchor_y_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_MOVE;
                    anchor_x_d = '0;
                    anchor_y_d = '0;
                end
            end
            S_MOVE:   state_d = S_SETTLE;
            S_SETTLE: state_d = S_WAIT;
            S_WAIT: begin
                if (all_final) begin
                    if (last_anchor) begin
                        state_d = S_DRAIN_MOVE;
                    end else begin
                        state_d = S_MOVE;
                        if (x_plus < X_LIM) begin
                            anchor_x_d = x_plus;
                        end else begin
                            anchor_x_d = '0;
                            anchor_y_d = anchor_y_q + 1'b1;
                        end
                    end
                end
            end
            S_DRAIN_MOVE:   state_d = S_DRAIN_SETTLE;
            S_DRAIN_SETTLE: state_d = S_DRAIN_WAIT;
            S_DRAIN_WAIT: begin
                if (all_final) begin
                    state_d = drain_last ? S_DONE : S_DRAIN_MOVE;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        frame_done_d = (state_d == S_DONE);
    end

    // state, anchor and done-pulse registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= S_IDLE;
            anchor_x_q   <= '0;
            anchor_y_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            anchor_x_q   <= anchor_x_d;
            anchor_y_q   <= anchor_y_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign anchor_moving = (state_q == S_MOVE) || (state_q == S_DRAIN_MOVE);
    assign flush         = (state_q == S_DRAIN_MOVE) || (state_q == S_DRAIN_SETTLE) ||
                           (state_q == S_DRAIN_WAIT);
    assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign frame_done    = frame_done_q;
    assign anchor_x      = anchor_x_q;
    assign anchor_y      = anchor_y_q;

endmodule

// File: tb/tb_anchor_scheduler.sv
// tb/tb_anchor_scheduler.sv - self-checking bench for anchor_scheduler
module tb_anchor_scheduler;

    localparam int W  = 20;
    localparam int H  = 2;
    localparam int ST = 10;
    localparam int NS = 4;

    logic          clk;
    logic          n_rst;
    logic          start;
    logic [NS-1:0] stage_final;
    logic          anchor_moving;
    logic [31:0]   anchor_x;
    logic [31:0]   anchor_y;
    logic          flush;
    logic          busy;
    logic          frame_done;

    anchor_scheduler #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .WIN_STEP   (ST),
        .NUM_STAGES (NS)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .start         (start),
        .stage_final   (stage_final),
        .anchor_moving (anchor_moving),
        .anchor_x      (anchor_x),
        .anchor_y      (anchor_y),
        .flush         (flush),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        f;
    } mv_t;

    typedef struct {
        int lat;
        bit poke;
        int exp_moves;
        int exp_cycles;
    } vec_t;

    mv_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  moves  = 0;
    int  dones  = 0;
    int  lat    = 0;
    int  low_cnt = 0;
    logic [NS-1:0] hold_mask = '0;

    assign stage_final = (low_cnt > 0) ? '0 : ~hold_mask;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // stage model: all stages drop final right after a move pulse and recover lat cycles later
    always @(negedge clk) begin
        if (anchor_moving && lat > 0) low_cnt = lat;
        else if (low_cnt > 0)         low_cnt = low_cnt - 1;
    end

    // scoreboard: every move pulse must match the next expected anchor
    always @(negedge clk) begin
        if (n_rst && anchor_moving) begin
            mv_t got;
            moves++;
            got = '{x: anchor_x, y: anchor_y, f: flush};
            if (exp_q.size() == 0) begin
                check("unexpected_move", 1, 0);
            end else begin
                mv_t e;
                e = exp_q.pop_front();
                check("move_anchor", got, e);
            end
        end
        if (n_rst && frame_done) dones++;
    end

    task automatic push_frame();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x += ST)
                exp_q.push_back('{x: x, y: y, f: 1'b0});
        for (int d = 0; d < NS - 1; d++)
            exp_q.push_back('{x: W - ST, y: H - 1, f: 1'b1});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        push_frame();
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // waits for frame_done; returns posedges counted since the start-sampling edge
    task automatic wait_done(input bit poke, output int cycles);
        cycles = 1;
        while (!frame_done && cycles < 2000) begin
            if (poke && cycles == 4) start = 1'b1;
            @(posedge clk);
            cycles++;
            @(negedge clk);
            start = 1'b0;
        end
        if (!frame_done) check("done_timeout", 0, 1);
        if (poke) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    vec_t vecs[5];
    int   m0, d0, cyc;

    initial begin
        vecs[0] = '{lat: 0, poke: 0, exp_moves: 7, exp_cycles: 22};
        vecs[1] = '{lat: 5, poke: 0, exp_moves: 7, exp_cycles: -1};
        vecs[2] = '{lat: 1, poke: 0, exp_moves: 7, exp_cycles: -1};
        vecs[3] = '{lat: 0, poke: 1, exp_moves: 7, exp_cycles: 22};
        vecs[4] = '{lat: 3, poke: 1, exp_moves: 7, exp_cycles: -1};

        start = 1'b0;
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_moving", anchor_moving, 0);
        check("rst_done", frame_done, 0);
        check("rst_xy", {anchor_x, anchor_y}, 0);
        n_rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            lat = vecs[i].lat;
            m0 = moves;
            d0 = dones;
            pulse_start();
            check("busy_after_start", busy, 1);
            wait_done(vecs[i].poke, cyc);
            if (vecs[i].exp_cycles >= 0 && !vecs[i].poke)
                check("frame_cycles", cyc, vecs[i].exp_cycles);
            repeat (4) @(negedge clk);
            check("moves_per_frame", moves - m0, vecs[i].exp_moves);
            check("done_pulses", dones - d0, 1);
            check("busy_idle", busy, 0);
            check("queue_empty", exp_q.size(), 0);
            check("anchor_hold", {anchor_x, anchor_y}, {32'(W - ST), 32'(H - 1)});
        end

        // stage 2 holds final low through the second window
        lat = 0;
        m0 = moves;
        pulse_start();
        cyc = 0;
        while (moves < m0 + 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        hold_mask = 4'b0100;
        m0 = moves;
        repeat (50) @(negedge clk);
        check("hold_no_move", moves - m0, 0);
        check("hold_anchor", {anchor_x, anchor_y}, {32'd10, 32'd0});
        hold_mask = '0;
        @(negedge clk);
        check("release_move", anchor_moving, 1);
        check("release_anchor", {anchor_x, anchor_y}, {32'd0, 32'd1});
        wait_done(1'b0, cyc);
        repeat (2) @(negedge clk);
        check("hold_queue_empty", exp_q.size(), 0);

        // asynchronous reset while parked in WAIT
        pulse_start();
        hold_mask = 4'b0001;
        repeat (8) @(negedge clk);
        d0 = dones;
        #2 n_rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_xy", {anchor_x, anchor_y}, 0);
        check("arst_flags", {anchor_moving, flush, frame_done}, 0);
        @(negedge clk);
        n_rst = 1'b1;
        hold_mask = '0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("arst_no_done", dones - d0, 0);
        m0 = moves;
        pulse_start();
        wait_done(1'b0, cyc);
        check("post_rst_cycles", cyc, 22);
        repeat (3) @(negedge clk);
        check("post_rst_moves", moves - m0, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
